// File: rtl/comb_bist_sweep.sv
// comb_bist_sweep: exhaustive-sweep self-test controller for a small combinational block.
// Walks every IN_W-bit stimulus value, holding each one for HOLD cycles. On the last
// cycle of each hold window the response is folded into a MISR. After the all-ones
// combination the signature is compared against golden and the verdict is latched.
module comb_bist_sweep #(
    parameter int              IN_W  = 4,
    parameter int              OUT_W = 3,
    parameter int              HOLD  = 3,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden,
    input  logic [OUT_W-1:0] resp,
    output logic [IN_W-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    // The hold counter needs at least one bit, even when HOLD == 1.
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [SIG_W-1:0]  SEED      = '1;
    localparam logic [IN_W-1:0]   STIM_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IN_W-1:0]     stim_q,  stim_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [SIG_W-1:0]    sig_q,   sig_d;
    logic                pass_q,  pass_d;

    logic [SIG_W-1:0]    resp_ext;
    logic [SIG_W-1:0]    misr_next;
    logic                sample_cycle;
    logic                last_combo;

    // The response is zero-extended to the MISR width before folding in.
    assign resp_ext = SIG_W'(resp);

    // One MISR step: shift left, XOR the polynomial when the top bit falls out,
    // then XOR in the current response. Built bit by bit so the taps are explicit.
    generate
        for (genvar gi = 0; gi < SIG_W; gi++) begin : g_misr
            if (gi == 0) begin : g_lsb
                assign misr_next[gi] = (sig_q[SIG_W-1] & POLY[gi]) ^ resp_ext[gi];
            end else begin : g_upper
                assign misr_next[gi] = sig_q[gi-1] ^ (sig_q[SIG_W-1] & POLY[gi]) ^ resp_ext[gi];
            end
        end
    endgenerate

    assign sample_cycle = (hold_q == HOLD_LAST);
    assign last_combo   = (stim_q == STIM_LAST);

    // Next-state and datapath updates; everything holds unless a transition says otherwise.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        hold_d  = hold_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    stim_d  = '0;
                    hold_d  = '0;
                    sig_d   = SEED;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    // Abort wins over a coincident sample: nothing is folded in.
                    state_d = ST_IDLE;
                    stim_d  = '0;
                    hold_d  = '0;
                    sig_d   = SEED;
                    pass_d  = 1'b0;
                end else if (sample_cycle) begin
                    sig_d  = misr_next;
                    hold_d = '0;
                    if (!last_combo) begin
                        stim_d = stim_q + IN_W'(1);
                    end else begin
                        // stim stays at all ones; the verdict uses the signature being written now.
                        pass_d  = (misr_next == golden);
                        state_d = ST_DONE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here; restart is from IDLE only.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset back to the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            hold_q  <= '0;
            sig_q   <= SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            hold_q  <= hold_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q == ST_DRIVE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_comb_bist_sweep.sv
// Directed bench for comb_bist_sweep: default-parameter instance driven by resp = stim[2:0],
// plus a minimal HOLD=1 / IN_W=1 / OUT_W=1 instance with resp = stim.
module tb_comb_bist_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] golden = 16'h0000;
    logic [2:0]  resp;
    logic [3:0]  stim;
    logic        busy, done, pass;
    logic [15:0] signature;

    logic        start_s = 1'b0;
    logic        abort_s = 1'b0;
    logic [15:0] golden_s = 16'h0000;
    logic        resp_s;
    logic        stim_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] signature_s;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] exp_sig;
    logic [15:0] exp_sig_s;

    assign resp   = stim[2:0];
    assign resp_s = stim_s;

    always #5 clk = ~clk;

    comb_bist_sweep dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden),
        .resp(resp), .stim(stim), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    comb_bist_sweep #(.IN_W(1), .OUT_W(1), .HOLD(1), .SIG_W(16), .POLY(16'h1021)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s), .golden(golden_s),
        .resp(resp_s), .stim(stim_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .signature(signature_s)
    );

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (stim !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL reset got stim=%h busy=%b done=%b pass=%b sig=%h want 0/0/0/0/ffff",
                     stim, busy, done, pass, signature);
        end
        tests_run++;
        if (stim_s !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0 || pass_s !== 1'b0 || signature_s !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL reset_small got stim=%b busy=%b done=%b pass=%b sig=%h want 0/0/0/0/ffff",
                     stim_s, busy_s, done_s, pass_s, signature_s);
        end
        rst = 1'b0;
        tick();
    endtask

    // Full sweep from IDLE; optionally pokes start during busy and during DONE.
    // Returns in the first IDLE cycle after done.
    task automatic run_full_sweep(input string tag, input logic [15:0] gold,
                                  input logic exp_pass, input bit poke);
        golden = gold;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 48; k++) begin
            tests_run++;
            if (busy !== 1'b1 || done !== 1'b0 || stim !== 4'(k / 3)) begin
                tests_failed++;
                $display("FAIL %s_drive k=%0d got busy=%b done=%b stim=%h want 1/0/%h",
                         tag, k, busy, done, stim, 4'(k / 3));
            end
            start = (poke && (k == 5 || k == 30)) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || signature !== exp_sig) begin
            tests_failed++;
            $display("FAIL %s_done got done=%b busy=%b pass=%b sig=%h want 1/0/%b/%h",
                     tag, done, busy, pass, signature, exp_pass, exp_sig);
        end
        start = poke ? 1'b1 : 1'b0;
        tick();
        start = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || stim !== 4'hF || signature !== exp_sig) begin
            tests_failed++;
            $display("FAIL %s_idle got done=%b busy=%b pass=%b stim=%h sig=%h want 0/0/%b/f/%h",
                     tag, done, busy, pass, stim, signature, exp_pass, exp_sig);
        end
    endtask

    task automatic test_sweep_pass();
        run_full_sweep("pass", exp_sig, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        bit seen;
        // abort in IDLE must leave the held result alone
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (stim !== 4'hF || pass !== 1'b1 || signature !== exp_sig || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle got stim=%h pass=%b sig=%h busy=%b want f/1/%h/0",
                     stim, pass, signature, busy, exp_sig);
        end
        golden = exp_sig;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        // DRIVE cycle 20 is also a sample cycle, so abort has to win over the fold.
        tests_run++;
        if (busy !== 1'b1 || stim !== 4'h6) begin
            tests_failed++;
            $display("FAIL abort_pre got busy=%b stim=%h want 1/6", busy, stim);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || stim !== 4'h0 || signature !== 16'hFFFF || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_post got busy=%b done=%b stim=%h sig=%h pass=%b want 0/0/0/ffff/0",
                     busy, done, stim, signature, pass);
        end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL abort_quiet got activity=1 want 0");
        end
        run_full_sweep("after_abort", exp_sig, 1'b1, 1'b0);
    endtask

    task automatic test_sweep_fail();
        run_full_sweep("fail", exp_sig ^ 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid();
        golden = exp_sig;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || stim !== 4'h3) begin
            tests_failed++;
            $display("FAIL rst_pre got busy=%b stim=%h want 1/3", busy, stim);
        end
        rst = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        tests_run++;
        if (stim !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL rst_mid got stim=%h busy=%b done=%b pass=%b sig=%h want 0/0/0/0/ffff",
                     stim, busy, done, pass, signature);
        end
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || stim !== 4'h0) begin
            tests_failed++;
            $display("FAIL rst_release got busy=%b stim=%h want 0/0", busy, stim);
        end
        run_full_sweep("start_ignored", exp_sig, 1'b1, 1'b1);
    endtask

    task automatic test_small();
        golden_s = exp_sig_s;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        tests_run++;
        if (busy_s !== 1'b1 || stim_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_c0 got busy=%b stim=%b want 1/0", busy_s, stim_s);
        end
        tick();
        tests_run++;
        if (busy_s !== 1'b1 || stim_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL small_c1 got busy=%b stim=%b want 1/1", busy_s, stim_s);
        end
        tick();
        tests_run++;
        if (busy_s !== 1'b0 || done_s !== 1'b1 || pass_s !== 1'b1 || signature_s !== exp_sig_s) begin
            tests_failed++;
            $display("FAIL small_done got busy=%b done=%b pass=%b sig=%h want 0/1/1/%h",
                     busy_s, done_s, pass_s, signature_s, exp_sig_s);
        end
        tick();
        tests_run++;
        if (done_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_idle got done=%b busy=%b want 0/0", done_s, busy_s);
        end
    endtask

    task automatic test_back_to_back();
        run_full_sweep("b2b_first", exp_sig, 1'b1, 1'b0);
        run_full_sweep("b2b_second", exp_sig, 1'b1, 1'b0);
    endtask

    initial begin
        exp_sig = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            exp_sig = misr_step(exp_sig, {13'd0, 3'(v)});
        end
        // Hand-derived: FFFF -> EFDF (resp 0) -> CF9E (resp 1)
        exp_sig_s = 16'hCF9E;

        test_reset();
        test_sweep_pass();
        test_abort();
        test_sweep_fail();
        test_rst_mid();
        test_small();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
